// File: rtl/key_pkg.sv
// Shared encodings for the key event path: event type codes and the
// per-key debounce state machine states.
package key_pkg;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_LONG    = 2'b10,
    EVT_RELEASE = 2'b11
  } evt_type_e;

  typedef enum logic [2:0] {
    KS_IDLE,
    KS_PRESS_DB,
    KS_PRESSED,
    KS_LONG,
    KS_RELEASE_DB
  } key_state_e;

  // Pending-bit slot order inside a key doubles as presentation priority.
  localparam int EVT_KINDS = 3;

  function automatic evt_type_e evt_code(input logic [1:0] kind);
    case (kind)
      2'd0:    return EVT_PRESS;
      2'd1:    return EVT_LONG;
      default: return EVT_RELEASE;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchroniser on the active-low pin, then a debounce /
// long-press state machine producing a level and one-cycle event pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int               CNT_W        = 25,
  parameter logic [CNT_W-1:0] DEBOUNCE_MAX = CNT_W'(999),
  parameter logic [CNT_W-1:0] LONG_MAX     = CNT_W'(24999)
) (
  input  logic clk_ss,
  input  logic rst_n,
  input  logic key_in,
  output logic level,
  output logic press_pulse,
  output logic long_pulse,
  output logic release_pulse
);

  logic [1:0]       sync;
  logic             s;
  key_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             long_fired;

  assign s = sync[1];

  // Synchroniser idles high so a released key never looks pressed after reset.
  always_ff @(posedge clk_ss or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], key_in};
  end

  always_ff @(posedge clk_ss or negedge rst_n) begin
    if (!rst_n) begin
      state         <= KS_IDLE;
      cnt           <= '0;
      long_fired    <= 1'b0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        KS_IDLE: begin
          if (!s) begin
            state <= KS_PRESS_DB;
            cnt   <= '0;
          end
        end
        KS_PRESS_DB: begin
          if (s) begin
            state <= KS_IDLE;
          end else if (cnt == DEBOUNCE_MAX) begin
            state       <= KS_PRESSED;
            cnt         <= '0;
            level       <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        KS_PRESSED: begin
          if (s) begin
            state <= KS_RELEASE_DB;
            cnt   <= '0;
          end else if (cnt == LONG_MAX) begin
            state      <= KS_LONG;
            long_fired <= 1'b1;
            long_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        KS_LONG: begin
          if (s) begin
            state <= KS_RELEASE_DB;
            cnt   <= '0;
          end
        end
        KS_RELEASE_DB: begin
          // A short high glitch returns to the held state with the long timer restarted.
          if (!s) begin
            state <= long_fired ? KS_LONG : KS_PRESSED;
            cnt   <= '0;
          end else if (cnt == DEBOUNCE_MAX) begin
            state         <= KS_IDLE;
            long_fired    <= 1'b0;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= KS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: per-key debouncers feed sticky pending bits, which
// drain by fixed priority into a single valid/ack event register.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int               NUM_KEYS     = 3,
  parameter int               CNT_W        = 25,
  parameter logic [CNT_W-1:0] DEBOUNCE_MAX = CNT_W'(999),
  parameter logic [CNT_W-1:0] LONG_MAX     = CNT_W'(24999)
) (
  input  logic                clk_ss,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic                evt_valid,
  output logic [2:0]          evt_key,
  output logic [1:0]          evt_type,
  input  logic                evt_ack,
  output logic                evt_ovf,
  input  logic                ovf_clr
);

  logic [NUM_KEYS-1:0][EVT_KINDS-1:0] pulse;
  logic [NUM_KEYS-1:0][EVT_KINDS-1:0] pending;
  logic [NUM_KEYS-1:0][EVT_KINDS-1:0] take;
  logic       load;
  logic       found;
  logic [2:0] sel_key;
  logic [1:0] sel_kind;
  logic       ovf_set;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .CNT_W       (CNT_W),
      .DEBOUNCE_MAX(DEBOUNCE_MAX),
      .LONG_MAX    (LONG_MAX)
    ) u_debounce (
      .clk_ss       (clk_ss),
      .rst_n        (rst_n),
      .key_in       (key_in[k]),
      .level        (key_level[k]),
      .press_pulse  (pulse[k][0]),
      .long_pulse   (pulse[k][1]),
      .release_pulse(pulse[k][2])
    );
  end

  assign load = !evt_valid || evt_ack;

  // Scan from the lowest priority upward so the last hit is the winner.
  always_comb begin
    found    = 1'b0;
    sel_key  = '0;
    sel_kind = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      for (int t = EVT_KINDS - 1; t >= 0; t--) begin
        if (pending[k][t]) begin
          found    = 1'b1;
          sel_key  = 3'(k);
          sel_kind = 2'(t);
        end
      end
    end
  end

  always_comb begin
    take = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      for (int t = 0; t < EVT_KINDS; t++) begin
        take[k][t] = load && found && (sel_key == 3'(k)) && (sel_kind == 2'(t));
      end
    end
  end

  assign ovf_set = |(pulse & pending & ~take);

  always_ff @(posedge clk_ss or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_type  <= EVT_NONE;
      evt_ovf   <= 1'b0;
    end else begin
      pending <= (pending & ~take) | pulse;
      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_key  <= sel_key;
          evt_type <= evt_code(sel_kind);
        end
      end
      if (ovf_set)      evt_ovf <= 1'b1;
      else if (ovf_clr) evt_ovf <= 1'b0;
    end
  end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Input-side counterpart of the board LED driver: samples raw push-button pins and synchronises and debounces them.
- Detects press, long-press and release per key.
- Queues the events as a single-entry valid/ack interface consumed by the CPU-side GPIO/interrupt logic.
- Sits between the board key pins and the peripheral register block, in the clk_ss domain.

Parameters:
NUM_KEYS, 3, number of keys (1..8)
CNT_W, 25, width of per-key timing counter
DEBOUNCE_MAX, 25'd999, stable-sample count minus 1 to qualify a press or release
LONG_MAX, 25'd24999, held-cycle count minus 1 after press qualification to fire long-press (must be > DEBOUNCE_MAX)

Ports:
clk_ss  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
key_in  in  NUM_KEYS  raw key pins, active-low (0 = pressed), asynchronous
key_level  out  NUM_KEYS  debounced level, 1 = pressed
evt_valid  out  1  event register holds an unconsumed event
evt_key  out  3  index of key for current event
evt_type  out  2  01 press, 10 long, 11 release (00 never while evt_valid=1)
evt_ack  in  1  consumer accepts event; meaningful only when evt_valid=1
evt_ovf  out  1  sticky: an event was lost
ovf_clr  in  1  clears evt_ovf

Behaviour:
- Reset values:
  - Synchroniser flops = 1.
  - All FSMs in IDLE, counters 0, long_fired 0.
  - key_level = 0, evt_valid = 0, evt_key = 0, evt_type = 00, evt_ovf = 0, pending bits = 0.
- Reset mid-operation drops all pending and presented events without emitting them.
- Synchroniser: 2-flop per key; the FSM uses the second flop output (s).
- Per-key FSM, one counter per key:
  - IDLE: s=0 -> PRESS_DB, cnt=0.
  - PRESS_DB:
    - s=1 -> IDLE (glitch, no event).
    - Otherwise, at cnt==DEBOUNCE_MAX -> PRESSED, cnt=0, one-cycle press pulse.
    - Otherwise cnt++.
  - PRESSED:
    - s=1 -> RELEASE_DB, cnt=0.
    - At cnt==LONG_MAX -> LONG, long_fired=1, one-cycle long pulse.
    - Otherwise cnt++.
  - LONG:
    - s=1 -> RELEASE_DB, cnt=0.
    - Counter holds; no repeat long events.
  - RELEASE_DB:
    - s=0 -> LONG if long_fired, else PRESSED; cnt=0 (glitch, no event).
    - At cnt==DEBOUNCE_MAX -> IDLE, long_fired=0, one-cycle release pulse.
    - Otherwise cnt++.
- key_level=1 in PRESSED, LONG and RELEASE_DB; 0 in IDLE and PRESS_DB.
- Counters never wrap; the compare happens before increment.
- Pending bits: 3 per key, one per type.
  - A pulse sets its bit on the next edge.
  - If the bit is already 1 and is not being consumed that cycle, evt_ovf<=1.
  - Pulse coincident with consumption of the same bit: the bit stays 1, no overflow.
- Presentation: when evt_valid=0, or evt_valid=1 and evt_ack=1, the event register loads the highest-priority pending bit and clears it.
  - Priority: lowest key index first; within a key, press, then long, then release.
  - If no bit is pending, evt_valid<=0.
- Hold rule: evt_key and evt_type are stable while evt_valid=1 and evt_ack=0.
- Latency: pulse at edge t -> pending at t+1 -> evt_valid at t+2 if the register is free.
- Back-to-back: ack with another event pending gives evt_valid continuously high with the new event the next cycle.
- evt_ovf: ovf_clr clears it. A simultaneous overflow set and ovf_clr leaves it 1 (set wins).
- Events always occur in press -> [long] -> release order per key. Releases are never lost unless the overflow rule fires.

Decomposition:
- Shared package key_pkg:
  - EVT_NONE/EVT_PRESS/EVT_LONG/EVT_RELEASE encodings.
  - FSM state encoding (KS_IDLE, KS_PRESS_DB, KS_PRESSED, KS_LONG, KS_RELEASE_DB).
- One sub-module, key_debounce: synchroniser + FSM + counter for one key.
  - Outputs: level, press, long and release pulses.
  - Instantiated NUM_KEYS times by generate.
- The top holds the pending bits, priority selection, event register and overflow logic.

Test Plan (DEBOUNCE_MAX=15, LONG_MAX=63, NUM_KEYS=3):
- Key0 low for 10 cycles then high -> no event, key_level stays 0, evt_valid stays 0.
- Key0 held low 40 cycles, ack immediately:
  - One press event (key 0, type 01); key_level[0]=1.
  - After release plus 16+2 stable cycles, one release event (type 11); no long event.
- Key1 held 120 cycles -> events press, long, release in order with evt_key=1. A 5-cycle high glitch during LONG yields no extra events.
- Keys 0 and 2 pressed on the same cycle, evt_ack held 0:
  - Key 0 press presented first, with fields stable until ack.
  - Ack -> key 2 press presented on the next cycle, evt_valid never dropping.
- evt_ack held 0 while key0 press/release repeats twice -> evt_ovf=1. ovf_clr pulse -> evt_ovf=0.
- rst_n asserted asynchronously mid-PRESS_DB with an event pending -> all outputs return to reset values immediately. No event is emitted after release of reset until a fresh qualified press.
